msrv32_dmem_bus_if: RTL

Data-memory bus master for the msrv32 core. It executes the load/store requests produced by the decode stage on a req/gnt/rvalid data bus. It builds byte masks and replicated write data for stores, and aligns and sign/zero-extends read data for loads. It stalls the pipeline for the duration of each access and reports bus errors and timeouts as access faults.

---
 rtl/msrv32_pkg.sv | 48 ++++
 rtl/msrv32_dmem_bus_if_if.sv | 39 +++
 rtl/msrv32_load_align.sv | 31 +++
 rtl/msrv32_dmem_bus_if.sv | 131 +++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared load/store constants, FSM state encoding and store formatting helpers
// for the msrv32 data-memory bus master.
package msrv32_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   // Wide enough to hold the value TIMEOUT_CYCLES itself.
   function automatic int cnt_width(input int unsigned timeout);
      return $clog2(timeout + 1);
   endfunction

   function automatic logic [3:0] st_mask(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      logic [3:0] m;
      m = 4'b1111;
      unique case (1'b1)
         (size == LS_BYTE): m = 4'b0001 << lo;
         (size == LS_HALF): m = 4'b0011 << {lo[1], 1'b0};
         default:           m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] st_wdata(
      input logic [1:0]  size,
      input logic [31:0] d
   );
      logic [31:0] w;
      w = d;
      unique case (1'b1)
         (size == LS_BYTE): w = {4{d[7:0]}};
         (size == LS_HALF): w = {2{d[15:0]}};
         default:           w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/msrv32_dmem_bus_if_if.sv
// req/gnt/rvalid data-memory bus bundle.
// master: drives req/we/addr/wmask/wdata; slave: drives gnt/rvalid/rdata/err.
interface msrv32_dmem_bus_if_if;

   logic        dmem_req_out;
   logic        dmem_we_out;
   logic [31:0] dmem_addr_out;
   logic [3:0]  dmem_wmask_out;
   logic [31:0] dmem_wdata_out;
   logic        dmem_gnt_in;
   logic        dmem_rvalid_in;
   logic [31:0] dmem_rdata_in;
   logic        dmem_err_in;

   modport master (
      output dmem_req_out,
      output dmem_we_out,
      output dmem_addr_out,
      output dmem_wmask_out,
      output dmem_wdata_out,
      input  dmem_gnt_in,
      input  dmem_rvalid_in,
      input  dmem_rdata_in,
      input  dmem_err_in
   );

   modport slave (
      input  dmem_req_out,
      input  dmem_we_out,
      input  dmem_addr_out,
      input  dmem_wmask_out,
      input  dmem_wdata_out,
      output dmem_gnt_in,
      output dmem_rvalid_in,
      output dmem_rdata_in,
      output dmem_err_in
   );

endinterface

// File: rtl/msrv32_load_align.sv
// Load data formatter: picks the addressed byte/half from a bus word and
// sign- or zero-extends it. Ports: i_rdata, i_addr_lo, i_size, i_unsigned -> o_data.
module msrv32_load_align
   import msrv32_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      o_data = i_rdata;
      unique case (1'b1)
         (i_size == LS_BYTE):
            o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         (i_size == LS_HALF):
            o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
         default:
            o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/msrv32_dmem_bus_if.sv
// Data-memory bus master: runs decode-stage loads/stores on the req/gnt/rvalid
// bus, stalls the pipeline meanwhile, reports done / access faults.
// Ports: decode request inputs, stall/done/load_data/fault outputs, bus master modport.
module msrv32_dmem_bus_if
   import msrv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        req_valid_in,
   input  logic        is_store_in,
   input  logic [1:0]  size_in,
   input  logic        load_unsigned_in,
   input  logic        misaligned_in,
   input  logic        trap_taken_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   output logic        stall_out,
   output logic        done_out,
   output logic [31:0] load_data_out,
   output logic        access_fault_out,
   msrv32_dmem_bus_if_if.master bus
);

   localparam int CW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_REQ  = ST_REQ;
   localparam logic [1:0] S_WAIT = ST_WAIT;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [3:0]    r_wmask;
   logic [31:0]   r_wdata;
   logic [1:0]    r_size;
   logic          r_uns;
   logic          r_done;
   logic          r_fault;
   logic [31:0]   r_load_data;

   logic          w_accept;
   logic [3:0]    w_mask;
   logic [31:0]   w_wdata;
   logic [31:0]   w_load;

   assign w_accept = (r_state == S_IDLE) & req_valid_in & ~misaligned_in
                   & ~trap_taken_in & (size_in != 2'b11);

   assign w_mask  = is_store_in ? st_mask(size_in, addr_in[1:0]) : 4'b0000;
   assign w_wdata = st_wdata(size_in, store_data_in);

   msrv32_load_align u_align (
      .i_rdata    (bus.dmem_rdata_in),
      .i_addr_lo  (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .o_data     (w_load)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wmask     <= '0;
         r_wdata     <= '0;
         r_size      <= '0;
         r_uns       <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
         r_load_data <= '0;
      end else begin
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_REQ;
                  r_we    <= is_store_in;
                  r_addr  <= addr_in;
                  r_wmask <= w_mask;
                  r_wdata <= w_wdata;
                  r_size  <= size_in;
                  r_uns   <= load_unsigned_in;
               end
            end
            S_REQ: begin
               // rvalid in this state cannot belong to us; only gnt matters
               if (bus.dmem_gnt_in) begin
                  r_state <= S_WAIT;
                  r_cnt   <= '0;
               end
            end
            S_WAIT: begin
               if (bus.dmem_rvalid_in) begin
                  r_state <= S_IDLE;
                  if (bus.dmem_err_in) begin
                     r_fault <= 1'b1;
                  end else begin
                     r_done <= 1'b1;
                     if (!r_we) r_load_data <= w_load;
                  end
               end else if (r_cnt == TO_MAX) begin
                  r_state <= S_IDLE;
                  r_fault <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_out        = (r_state != S_IDLE) | w_accept;
   assign done_out         = r_done;
   assign access_fault_out = r_fault;
   assign load_data_out    = r_load_data;

   assign bus.dmem_req_out   = (r_state == S_REQ);
   assign bus.dmem_we_out    = r_we;
   assign bus.dmem_addr_out  = {r_addr[31:2], 2'b00};
   assign bus.dmem_wmask_out = r_wmask;
   assign bus.dmem_wdata_out = r_wdata;

endmodule
